// File: rtl/saida_serial_pkg.sv
// Shared definitions for the multi-character serial transmitter:
// FSM state codes, parity-mode constants and the 7-segment decoder.
package saida_serial_pkg;

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        PREPARA   = 4'd1,
        TRANSMITE = 4'd2,
        PROXIMO   = 4'd3,
        FINAL     = 4'd4
    } estado_t;

    localparam int PARIDADE_NENHUMA = 0;
    localparam int PARIDADE_PAR     = 1;
    localparam int PARIDADE_IMPAR   = 2;

    // Active-low 7-segment pattern, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] hexa7seg(input logic [3:0] codigo);
        logic [6:0] seg;
        case (codigo)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'ha:    seg = 7'b0001000;
            4'hb:    seg = 7'b0000011;
            4'hc:    seg = 7'b1000110;
            4'hd:    seg = 7'b0100001;
            4'he:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/saida_serial_multi_contador_m.sv
// Bit-time tick generator: counts 0..M-1 while enabled and flags the
// last cycle of each bit period on fim.
module contador_m #(
    parameter int M = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);
    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] MAXIMO = W'(M - 1);

    logic [W-1:0] cnt;

    // Wrapping counter, cleared by reset or by the datapath at frame load.
    always_ff @(posedge clock) begin
        if (reset || zera)
            cnt <= '0;
        else if (conta)
            cnt <= (cnt == MAXIMO) ? '0 : cnt + 1'b1;
    end

    assign fim = conta && (cnt == MAXIMO);

endmodule

// File: rtl/saida_serial_multi_fd.sv
// Datapath: payload capture register, per-character frame builder,
// output shift register, bit counter, character index and tick generator.
module saida_serial_multi_fd
    import saida_serial_pkg::*;
#(
    parameter int NUM_CHARS    = 3,
    parameter int DATA_BITS    = 7,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 2,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           captura,
    input  logic                           carrega,
    input  logic                           transmite,
    input  logic                           avanca,
    input  logic [NUM_CHARS*DATA_BITS-1:0] dados,
    output logic                           saida_serial,
    output logic                           fim_tick,
    output logic                           ultimo_bit,
    output logic                           ultimo_char
);
    localparam int PB         = (PARITY != PARIDADE_NENHUMA) ? 1 : 0;
    localparam int FRAME_BITS = 1 + DATA_BITS + PB + STOP_BITS;
    localparam int IDX_W      = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam logic [IDX_W-1:0] ULTIMO_IDX = IDX_W'(NUM_CHARS - 1);
    localparam logic [BIT_W-1:0] ULTIMO_BIT = BIT_W'(FRAME_BITS - 1);

    logic [NUM_CHARS*DATA_BITS-1:0] dados_reg;
    logic [IDX_W-1:0]               idx;
    logic [FRAME_BITS-1:0]          sr;
    logic [BIT_W-1:0]               bit_cnt;
    logic [DATA_BITS-1:0]           caractere;

    // Bit 0 goes out first: start, data LSB first, optional parity, stops.
    function automatic logic [FRAME_BITS-1:0] monta_quadro(input logic [DATA_BITS-1:0] c);
        logic [FRAME_BITS-1:0] q;
        logic                  p;
        q = '1;
        q[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++)
            q[1+i] = c[i];
        p = ^c;
        if (PARITY == PARIDADE_IMPAR)
            p = ~p;
        if (PB == 1)
            q[DATA_BITS+1] = p;
        return q;
    endfunction

    assign caractere = dados_reg[idx*DATA_BITS +: DATA_BITS];

    // Payload is frozen at acceptance; the index walks through characters.
    always_ff @(posedge clock) begin
        if (reset) begin
            dados_reg <= '0;
            idx       <= '0;
        end else if (captura) begin
            dados_reg <= dados;
            idx       <= '0;
        end else if (avanca) begin
            idx <= idx + 1'b1;
        end
    end

    // Line register: ones shift in behind the frame, so the line idles high.
    always_ff @(posedge clock) begin
        if (reset) begin
            sr      <= '1;
            bit_cnt <= '0;
        end else if (carrega) begin
            sr      <= monta_quadro(caractere);
            bit_cnt <= '0;
        end else if (fim_tick) begin
            sr      <= {1'b1, sr[FRAME_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    contador_m #(.M(CLKS_PER_BIT)) u_tick (
        .clock (clock),
        .reset (reset),
        .zera  (carrega),
        .conta (transmite),
        .fim   (fim_tick)
    );

    assign saida_serial = sr[0];
    assign ultimo_bit   = (bit_cnt == ULTIMO_BIT);
    assign ultimo_char  = (idx == ULTIMO_IDX);

endmodule

// File: rtl/saida_serial_multi_uc.sv
// Control unit: sequences prepare / transmit / next-character / final,
// with registered pronto and ocupado.
module saida_serial_multi_uc
    import saida_serial_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    inicio,
    input  logic    fim_tick,
    input  logic    ultimo_bit,
    input  logic    ultimo_char,
    output logic    captura,
    output logic    carrega,
    output logic    transmite,
    output logic    avanca,
    output logic    pronto,
    output logic    ocupado,
    output estado_t estado
);
    // State register and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= INICIAL;
            pronto  <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                INICIAL: begin
                    if (inicio) begin
                        estado  <= PREPARA;
                        ocupado <= 1'b1;
                    end
                end
                PREPARA: estado <= TRANSMITE;
                TRANSMITE: begin
                    if (fim_tick && ultimo_bit) begin
                        if (ultimo_char) begin
                            estado  <= FINAL;
                            pronto  <= 1'b1;
                            ocupado <= 1'b0;
                        end else begin
                            estado <= PROXIMO;
                        end
                    end
                end
                PROXIMO: estado <= PREPARA;
                FINAL:   estado <= INICIAL;
                default: begin
                    estado  <= INICIAL;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign captura   = (estado == INICIAL) && inicio;
    assign carrega   = (estado == PREPARA);
    assign transmite = (estado == TRANSMITE);
    assign avanca    = (estado == PROXIMO);

endmodule

// File: rtl/saida_serial_multi.sv
// Multi-character asynchronous serial transmitter (top level).
// Protocol: inicio is a level request taken only while idle; the payload
// is captured on that edge, ocupado stays high while characters are sent,
// and pronto pulses for one cycle when the last stop bit has finished.
module saida_serial_multi
    import saida_serial_pkg::*;
#(
    parameter int NUM_CHARS    = 3,
    parameter int DATA_BITS    = 7,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 2,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           inicio,
    input  logic [NUM_CHARS*DATA_BITS-1:0] dados,
    output logic                           saida_serial,
    output logic                           pronto,
    output logic                           ocupado,
    output logic                           db_inicio,
    output logic                           db_saida_serial,
    output logic [6:0]                     db_estado
);
    logic    captura, carrega, transmite, avanca;
    logic    fim_tick, ultimo_bit, ultimo_char;
    estado_t estado;

    saida_serial_multi_fd #(
        .NUM_CHARS    (NUM_CHARS),
        .DATA_BITS    (DATA_BITS),
        .PARITY       (PARITY),
        .STOP_BITS    (STOP_BITS),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_fd (
        .clock        (clock),
        .reset        (reset),
        .captura      (captura),
        .carrega      (carrega),
        .transmite    (transmite),
        .avanca       (avanca),
        .dados        (dados),
        .saida_serial (saida_serial),
        .fim_tick     (fim_tick),
        .ultimo_bit   (ultimo_bit),
        .ultimo_char  (ultimo_char)
    );

    saida_serial_multi_uc u_uc (
        .clock       (clock),
        .reset       (reset),
        .inicio      (inicio),
        .fim_tick    (fim_tick),
        .ultimo_bit  (ultimo_bit),
        .ultimo_char (ultimo_char),
        .captura     (captura),
        .carrega     (carrega),
        .transmite   (transmite),
        .avanca      (avanca),
        .pronto      (pronto),
        .ocupado     (ocupado),
        .estado      (estado)
    );

    assign db_inicio       = inicio;
    assign db_saida_serial = saida_serial;
    assign db_estado       = hexa7seg(estado);

endmodule

// File: tb/tb_saida_serial_multi.sv
// Directed bench for saida_serial_multi with CLKS_PER_BIT=4: three-character
// even parity, single-character odd parity and single-character no parity.
module tb_saida_serial_multi;

    localparam int CPB      = 4;
    localparam int CHAR_LEN = 2 + 11 * CPB;   // 46 cycles per character slot
    localparam int TX_LEN   = 3 * CHAR_LEN;   // 138
    localparam int ODD_LEN  = 2 + 11 * CPB;   // 46
    localparam int NONE_LEN = 2 + 10 * CPB;   // 42

    // Frames in send order: element 0 is the first bit on the line.
    localparam logic [0:10] FRAME_A    = 11'b0_1000001_0_11;
    localparam logic [0:10] FRAME_B    = 11'b0_0100001_0_11;
    localparam logic [0:10] FRAME_C    = 11'b0_1100001_1_11;
    localparam logic [0:10] FRAME_ODD  = 11'b0_0000000_1_11;
    localparam logic [0:9]  FRAME_NONE = 10'b0_1010101_11;

    logic        clock, reset;
    logic        inicio, saida_serial, pronto, ocupado, db_inicio, db_saida_serial;
    logic [20:0] dados;
    logic [6:0]  db_estado;
    logic        inicio_o, saida_o, pronto_o, ocupado_o, dbi_o, dbs_o;
    logic [6:0]  dados_o, dbe_o;
    logic        inicio_n, saida_n, pronto_n, ocupado_n, dbi_n, dbs_n;
    logic [6:0]  dados_n, dbe_n;

    int n_checks = 0;
    int n_fail   = 0;

    saida_serial_multi #(.NUM_CHARS(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .inicio(inicio), .dados(dados),
        .saida_serial(saida_serial), .pronto(pronto), .ocupado(ocupado),
        .db_inicio(db_inicio), .db_saida_serial(db_saida_serial), .db_estado(db_estado)
    );

    saida_serial_multi #(.NUM_CHARS(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) dut_odd (
        .clock(clock), .reset(reset), .inicio(inicio_o), .dados(dados_o),
        .saida_serial(saida_o), .pronto(pronto_o), .ocupado(ocupado_o),
        .db_inicio(dbi_o), .db_saida_serial(dbs_o), .db_estado(dbe_o)
    );

    saida_serial_multi #(.NUM_CHARS(1), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) dut_none (
        .clock(clock), .reset(reset), .inicio(inicio_n), .dados(dados_n),
        .saida_serial(saida_n), .pronto(pronto_n), .ocupado(ocupado_n),
        .db_inicio(dbi_n), .db_saida_serial(dbs_n), .db_estado(dbe_n)
    );

    // Clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected line level in cycle c (1 = first cycle after acceptance).
    function automatic logic exp_line3(input int c);
        int j, r;
        j = (c - 1) / CHAR_LEN;
        r = c - j * CHAR_LEN;
        if (c < 1 || r < 2 || r > CHAR_LEN - 1) return 1'b1;
        case (j)
            0:       return FRAME_A[(r - 2) / CPB];
            1:       return FRAME_B[(r - 2) / CPB];
            default: return FRAME_C[(r - 2) / CPB];
        endcase
    endfunction

    // Expected state code in cycle c (0 = idle).
    function automatic int exp_state3(input int c);
        int j, r;
        if (c < 1) return 0;
        j = (c - 1) / CHAR_LEN;
        r = c - j * CHAR_LEN;
        if (r == 1) return 1;
        if (r <= CHAR_LEN - 1) return 2;
        return (j < 2) ? 3 : 4;
    endfunction

    function automatic logic [6:0] seg_of(input int s);
        case (s)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            default: return 7'b0011001;
        endcase
    endfunction

    // Driver: present inicio for one accepting edge, leave sampling point in cycle 1.
    task automatic start_main();
        @(negedge clock);
        inicio = 1'b1;
        @(posedge clock);
        #1;
        inicio = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; inicio = 1'b1; inicio_o = 1'b1; inicio_n = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        n_checks++; if (saida_serial !== 1'b1) begin n_fail++; $display("FAIL reset_line got %b want 1", saida_serial); end
        n_checks++; if (pronto !== 1'b0) begin n_fail++; $display("FAIL reset_pronto got %b want 0", pronto); end
        n_checks++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado got %b want 0", ocupado); end
        n_checks++; if (db_estado !== 7'b1000000) begin n_fail++; $display("FAIL reset_estado got %b want 1000000", db_estado); end
        n_checks++; if (db_inicio !== 1'b1) begin n_fail++; $display("FAIL reset_db_inicio got %b want 1", db_inicio); end
        n_checks++; if (saida_o !== 1'b1 || ocupado_o !== 1'b0) begin n_fail++; $display("FAIL reset_odd got %b%b want 10", saida_o, ocupado_o); end
        n_checks++; if (saida_n !== 1'b1 || ocupado_n !== 1'b0) begin n_fail++; $display("FAIL reset_none got %b%b want 10", saida_n, ocupado_n); end
        inicio = 1'b0; inicio_o = 1'b0; inicio_n = 1'b0; reset = 1'b0;
        #1;
        n_checks++; if (db_inicio !== 1'b0) begin n_fail++; $display("FAIL idle_db_inicio got %b want 0", db_inicio); end
        @(posedge clock); #1;
        n_checks++; if (db_estado !== 7'b1000000) begin n_fail++; $display("FAIL idle_estado got %b want 1000000", db_estado); end
    endtask

    task automatic test_basic_frames();
        dados = {7'h43, 7'h42, 7'h41};
        start_main();
        for (int c = 1; c <= TX_LEN; c++) begin
            n_checks++; if (saida_serial !== exp_line3(c)) begin n_fail++; $display("FAIL basic_line cycle %0d got %b want %b", c, saida_serial, exp_line3(c)); end
            n_checks++; if (db_saida_serial !== exp_line3(c)) begin n_fail++; $display("FAIL basic_db_line cycle %0d got %b want %b", c, db_saida_serial, exp_line3(c)); end
            n_checks++; if (pronto !== (c == TX_LEN)) begin n_fail++; $display("FAIL basic_pronto cycle %0d got %b want %b", c, pronto, c == TX_LEN); end
            n_checks++; if (ocupado !== (c < TX_LEN)) begin n_fail++; $display("FAIL basic_ocupado cycle %0d got %b want %b", c, ocupado, c < TX_LEN); end
            n_checks++; if (db_estado !== seg_of(exp_state3(c))) begin n_fail++; $display("FAIL basic_estado cycle %0d got %b want %b", c, db_estado, seg_of(exp_state3(c))); end
            @(posedge clock); #1;
        end
        n_checks++; if (saida_serial !== 1'b1 || pronto !== 1'b0 || db_estado !== 7'b1000000) begin
            n_fail++; $display("FAIL basic_after line %b pronto %b estado %b want 1 0 1000000", saida_serial, pronto, db_estado);
        end
    endtask

    task automatic test_odd_parity();
        dados_o = 7'h00;
        @(negedge clock); inicio_o = 1'b1;
        @(posedge clock); #1; inicio_o = 1'b0;
        for (int c = 1; c <= ODD_LEN; c++) begin
            logic e;
            e = (c >= 2 && c <= ODD_LEN - 1) ? FRAME_ODD[(c - 2) / CPB] : 1'b1;
            n_checks++; if (saida_o !== e) begin n_fail++; $display("FAIL odd_line cycle %0d got %b want %b", c, saida_o, e); end
            n_checks++; if (pronto_o !== (c == ODD_LEN)) begin n_fail++; $display("FAIL odd_pronto cycle %0d got %b want %b", c, pronto_o, c == ODD_LEN); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_no_parity();
        dados_n = 7'h55;
        @(negedge clock); inicio_n = 1'b1;
        @(posedge clock); #1; inicio_n = 1'b0;
        for (int c = 1; c <= NONE_LEN; c++) begin
            logic e;
            e = (c >= 2 && c <= NONE_LEN - 1) ? FRAME_NONE[(c - 2) / CPB] : 1'b1;
            n_checks++; if (saida_n !== e) begin n_fail++; $display("FAIL none_line cycle %0d got %b want %b", c, saida_n, e); end
            n_checks++; if (pronto_n !== (c == NONE_LEN)) begin n_fail++; $display("FAIL none_pronto cycle %0d got %b want %b", c, pronto_n, c == NONE_LEN); end
            n_checks++; if (ocupado_n !== (c < NONE_LEN)) begin n_fail++; $display("FAIL none_ocupado cycle %0d got %b want %b", c, ocupado_n, c < NONE_LEN); end
            @(posedge clock); #1;
        end
        n_checks++; if (pronto_n !== 1'b0 || saida_n !== 1'b1) begin n_fail++; $display("FAIL none_after pronto %b line %b want 0 1", pronto_n, saida_n); end
    endtask

    task automatic test_ignore_inicio();
        dados = {7'h43, 7'h42, 7'h41};
        start_main();
        for (int c = 1; c <= TX_LEN; c++) begin
            n_checks++; if (saida_serial !== exp_line3(c)) begin n_fail++; $display("FAIL ignore_line cycle %0d got %b want %b", c, saida_serial, exp_line3(c)); end
            n_checks++; if (pronto !== (c == TX_LEN)) begin n_fail++; $display("FAIL ignore_pronto cycle %0d got %b want %b", c, pronto, c == TX_LEN); end
            if (c == 20 || c == 60 || c == 100) begin dados = 21'h0AAAAA ^ 21'(c); inicio = 1'b1; end
            else inicio = 1'b0;
            @(posedge clock); #1;
        end
        inicio = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        dados = {7'h43, 7'h42, 7'h41};
        start_main();
        for (int c = 1; c <= 60; c++) begin
            n_checks++; if (saida_serial !== exp_line3(c)) begin n_fail++; $display("FAIL midrst_line cycle %0d got %b want %b", c, saida_serial, exp_line3(c)); end
            if (c < 60) begin @(posedge clock); #1; end
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_checks++; if (saida_serial !== 1'b1) begin n_fail++; $display("FAIL midrst_line_after got %b want 1", saida_serial); end
        n_checks++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL midrst_ocupado got %b want 0", ocupado); end
        n_checks++; if (db_estado !== 7'b1000000) begin n_fail++; $display("FAIL midrst_estado got %b want 1000000", db_estado); end
        for (int k = 0; k < 100; k++) begin
            n_checks++; if (pronto !== 1'b0 || saida_serial !== 1'b1) begin n_fail++; $display("FAIL midrst_quiet step %0d pronto %b line %b want 0 1", k, pronto, saida_serial); end
            @(posedge clock); #1;
        end
        start_main();
        for (int c = 1; c <= TX_LEN; c++) begin
            n_checks++; if (saida_serial !== exp_line3(c)) begin n_fail++; $display("FAIL restart_line cycle %0d got %b want %b", c, saida_serial, exp_line3(c)); end
            n_checks++; if (pronto !== (c == TX_LEN)) begin n_fail++; $display("FAIL restart_pronto cycle %0d got %b want %b", c, pronto, c == TX_LEN); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        dados = {7'h43, 7'h42, 7'h41};
        @(negedge clock); inicio = 1'b1;
        @(posedge clock); #1;
        for (int c = 1; c <= 2 * TX_LEN + 1; c++) begin
            int  cc;
            logic el;
            cc = (c <= TX_LEN) ? c : c - (TX_LEN + 1);
            el = exp_line3(cc);
            n_checks++; if (saida_serial !== el) begin n_fail++; $display("FAIL b2b_line cycle %0d got %b want %b", c, saida_serial, el); end
            n_checks++; if (pronto !== (cc == TX_LEN)) begin n_fail++; $display("FAIL b2b_pronto cycle %0d got %b want %b", c, pronto, cc == TX_LEN); end
            n_checks++; if (ocupado !== (cc >= 1 && cc < TX_LEN)) begin n_fail++; $display("FAIL b2b_ocupado cycle %0d got %b want %b", c, ocupado, cc >= 1 && cc < TX_LEN); end
            n_checks++; if (db_estado !== seg_of(exp_state3(cc))) begin n_fail++; $display("FAIL b2b_estado cycle %0d got %b want %b", c, db_estado, seg_of(exp_state3(cc))); end
            if (c == 2 * TX_LEN + 1) inicio = 1'b0;
            @(posedge clock); #1;
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (db_estado !== 7'b1000000 || ocupado !== 1'b0 || saida_serial !== 1'b1) begin
                n_fail++; $display("FAIL b2b_idle step %0d estado %b ocupado %b line %b", k, db_estado, ocupado, saida_serial);
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset = 1'b1; inicio = 1'b0; dados = '0;
        inicio_o = 1'b0; dados_o = '0; inicio_n = 1'b0; dados_n = '0;
        test_reset();
        test_basic_frames();
        test_odd_parity();
        test_no_parity();
        test_ignore_inicio();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/saida_serial_multi.md
SAIDA_SERIAL_MULTI -- requirements
Module: saida_serial_multi

Interface
REQ-001 Parameter NUM_CHARS, default 3, number of characters sent per transmission (1..8).
REQ-002 Parameter DATA_BITS, default 7, data bits per character (5..8).
REQ-003 Parameter PARITY, default 1, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 2, stop bits per character (1 or 2).
REQ-005 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (>=2).
REQ-006 Port clock  input  1  system clock; all state changes on its rising edge.
REQ-007 Port reset  input  1  synchronous, active-high reset.
REQ-008 Port inicio  input  1  start request; level-sampled in INICIAL only.
REQ-009 Port dados  input  NUM_CHARS*DATA_BITS  payload; character 0 in bits [DATA_BITS-1:0], sent first.
REQ-010 Port saida_serial  output  1  serial line; idle high.
REQ-011 Port pronto  output  1  one-cycle pulse when the whole transmission completes.
REQ-012 Port ocupado  output  1  high from the cycle after inicio is accepted until pronto is asserted.
REQ-013 Port db_inicio  output  1  copy of inicio.
REQ-014 Port db_saida_serial  output  1  copy of saida_serial.
REQ-015 Port db_estado  output  7  7-segment code (active-low segments g..a) of the 4-bit state code.

Function
REQ-016 FSM states and codes: INICIAL 0, PREPARA 1, TRANSMITE 2, PROXIMO 3, FINAL 4; all other codes return to INICIAL.
REQ-017 INICIAL: line high, ocupado low; inicio=1 at an edge moves to PREPARA and captures dados into an internal register.
REQ-018 PREPARA (1 cycle): loads the frame of character idx into the bit shift register, clears the bit and tick counters, then moves to TRANSMITE.
REQ-019 Frame order: start bit 0, DATA_BITS data LSB first, parity bit if PARITY!=0, then STOP_BITS bits of 1.
REQ-020 Even parity: the parity bit makes the total count of ones in data+parity even; odd parity makes it odd.
REQ-021 TRANSMITE holds each bit on saida_serial for exactly CLKS_PER_BIT cycles; the line is registered and glitch-free.
REQ-022 After the last stop bit's final cycle: PROXIMO if idx<NUM_CHARS-1 (idx increments, back to PREPARA), else FINAL.
REQ-023 Line stays high during PREPARA and PROXIMO, so consecutive characters are separated by exactly 2 idle cycles.
REQ-024 FINAL (1 cycle): pronto=1, ocupado=0, line high, then INICIAL.
REQ-025 inicio while not in INICIAL is ignored; changes to dados after capture do not affect the transmission in progress.
REQ-026 inicio held high continuously restarts a new transmission in the cycle after FINAL (back-to-back operation).
REQ-027 The character index counter is ceil(log2(NUM_CHARS)) bits wide, minimum 1; the tick counter is ceil(log2(CLKS_PER_BIT)) bits wide.
REQ-028 Total transmission length from the inicio-accepting edge to pronto: NUM_CHARS*(2+(1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT) cycles.

Reset
REQ-029 reset=1 at an edge forces INICIAL, saida_serial=1, pronto=0, ocupado=0, idx=0, all counters 0, from the next cycle.
REQ-030 Reset mid-frame aborts the transmission immediately, with no pronto pulse; reset has priority over inicio.

Structure
REQ-031 State codes, parity-mode constants and the 7-segment table belong in the shared package saida_serial_pkg.
REQ-032 Split into datapath saida_serial_multi_fd (capture register, frame builder, shift register, counters) and control unit saida_serial_multi_uc (FSM).
REQ-033 The bit-time tick generator is the one sub-module, contador_m, parameterised by CLKS_PER_BIT, with a 1-cycle fim output.

Verification (CLKS_PER_BIT=4, NUM_CHARS=3, DATA_BITS=7, PARITY=1, STOP_BITS=2 unless stated)
REQ-034 dados={7'h43,7'h42,7'h41}, inicio pulse -> line carries A,B,C frames 0,1000001,0,11 / 0,0100001,0,11 / 0,1100001,1,11 (LSB first); pronto at cycle 3*(2+11*4)=138.
REQ-035 PARITY=2, single char 7'h00 (NUM_CHARS=1) -> parity bit 1; PARITY=0 -> frame is 10 bits long; pronto at cycle 2+10*4=42.
REQ-036 inicio re-pulsed mid-transmission with different dados -> transmitted bits and pronto timing are unchanged from REQ-034.
REQ-037 reset during the data bits of character 1 -> saida_serial=1, ocupado=0 from the next cycle, no pronto, and a fresh inicio restarts from character 0.
REQ-038 inicio held high -> a second identical transmission starts the cycle after pronto; db_estado shows the 7-segment code for 0..4 in sequence.
